// File: rtl/lenet_pkg.sv
// Shared LeNet-5 definitions for the C3 convolution sequencer:
// layer geometry, controller state encoding and the result coordinate tag.
package lenet_pkg;

    localparam int K        = 5;
    localparam int IN_DIM   = 14;
    localparam int OUT_DIM  = IN_DIM - K + 1;
    localparam int NUM_FILT = 16;
    localparam int FW       = 4;
    localparam int CW       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } conv_ctrl_state_t;

    typedef struct packed {
        logic [FW-1:0] filt;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
    } conv_tag_t;

    // Output column produced when input column `col` completes a window.
    function automatic logic [CW-1:0] out_col_of(input logic [CW-1:0] col);
        return col - CW'(K - 1);
    endfunction

endpackage

// File: rtl/conv554_ctrl_if.sv
// Control/handshake bundle between conv554_ctrl and the window buffer,
// weight ROM, conv554 datapath and the S4 write-back stage.
interface conv554_ctrl_if #(
    parameter int FW = lenet_pkg::FW,
    parameter int CW = lenet_pkg::CW
) ();

    logic          start;
    logic          busy;
    logic          done;
    logic [FW-1:0] filt_sel;
    logic          filt_load;
    logic [CW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic          conv_en;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_filt;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;

    modport master (
        input  start, out_ready,
        output busy, done, filt_sel, filt_load, rd_row, rd_col, conv_en,
               out_valid, out_filt, out_row, out_col
    );

    modport slave (
        output start, out_ready,
        input  busy, done, filt_sel, filt_load, rd_row, rd_col, conv_en,
               out_valid, out_filt, out_row, out_col
    );

endinterface

// File: rtl/conv_addr_gen.sv
// Nested column/row/filter counter for the C3 sweep; advances one input
// column per step and reports end-of-filter, end-of-layer and result tags.
module conv_addr_gen #(
    parameter int IN_DIM   = 14,
    parameter int K        = 5,
    parameter int NUM_FILT = 16,
    parameter int FW       = 4,
    parameter int CW       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 step,
    output logic [FW-1:0]        filt_r,
    output logic [CW-1:0]        row_r,
    output logic [CW-1:0]        col_r,
    output logic                 filt_end_s,
    output logic                 last_s,
    output logic                 issue_valid_s,
    output lenet_pkg::conv_tag_t tag_s
);
    import lenet_pkg::*;

    localparam int OUT_DIM = IN_DIM - K + 1;

    logic row_wrap_s;

    assign row_wrap_s    = (col_r == CW'(IN_DIM - 1));
    assign filt_end_s    = row_wrap_s && (row_r == CW'(OUT_DIM - 1));
    assign last_s        = filt_end_s && (filt_r == FW'(NUM_FILT - 1));
    // Columns before K-1 only fill the window and complete no result.
    assign issue_valid_s = (col_r >= CW'(K - 1));
    assign tag_s         = '{filt: filt_r, row: row_r, col: out_col_of(col_r)};

    // Column counter carries into row, row carries into filter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_r <= {FW{1'b0}};
            row_r  <= {CW{1'b0}};
            col_r  <= {CW{1'b0}};
        end else if (clear) begin
            filt_r <= {FW{1'b0}};
            row_r  <= {CW{1'b0}};
            col_r  <= {CW{1'b0}};
        end else if (step) begin
            if (row_wrap_s) begin
                col_r <= {CW{1'b0}};
                if (filt_end_s) begin
                    row_r <= {CW{1'b0}};
                    if (!last_s) begin
                        filt_r <= filt_r + FW'(1);
                    end
                end else begin
                    row_r <= row_r + CW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/conv554_ctrl.sv
// Sequencer for the 4-channel 5x5 conv554 datapath of LeNet-5 C3: walks
// filters/rows/columns, tags each result and honours S4 backpressure.
module conv554_ctrl #(
    parameter int IN_DIM   = 14,
    parameter int K        = 5,
    parameter int NUM_FILT = 16,
    parameter int FW       = 4,
    parameter int CW       = 4
) (
    input  logic           clk,
    input  logic           rst,
    conv554_ctrl_if.master bus
);
    import lenet_pkg::*;

    conv_ctrl_state_t state_r;
    logic             busy_r;
    logic             done_r;
    logic             filt_load_r;
    logic             out_valid_r;
    conv_tag_t        out_tag_r;

    logic [FW-1:0]    filt_r;
    logic [CW-1:0]    row_r;
    logic [CW-1:0]    col_r;
    logic             filt_end_s;
    logic             last_s;
    logic             issue_valid_s;
    conv_tag_t        tag_s;
    logic             clear_s;
    logic             conv_en_s;

    assign clear_s   = (state_r == IDLE);
    // A refused result freezes the datapath so convValue and the tag hold.
    assign conv_en_s = (state_r == STREAM) && !(out_valid_r && !bus.out_ready);

    conv_addr_gen #(
        .IN_DIM   (IN_DIM),
        .K        (K),
        .NUM_FILT (NUM_FILT),
        .FW       (FW),
        .CW       (CW)
    ) u_addr_gen (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear_s),
        .step          (conv_en_s),
        .filt_r        (filt_r),
        .row_r         (row_r),
        .col_r         (col_r),
        .filt_end_s    (filt_end_s),
        .last_s        (last_s),
        .issue_valid_s (issue_valid_s),
        .tag_s         (tag_s)
    );

    // Layer sequencing FSM; FINISH raises done once the last result retires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            filt_load_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r     <= LOAD;
                        busy_r      <= 1'b1;
                        filt_load_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                LOAD: begin
                    filt_load_r <= 1'b0;
                    state_r     <= STREAM;
                end
                STREAM: begin
                    if (conv_en_s && filt_end_s) begin
                        if (last_s) begin
                            state_r <= FINISH;
                        end else begin
                            state_r     <= LOAD;
                            filt_load_r <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    if (done_r) begin
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (!out_valid_r) begin
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    filt_load_r <= 1'b0;
                end
            endcase
        end
    end

    // Result slot: a new issue overwrites (even on accept), acceptance retires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_tag_r   <= '{filt: {FW{1'b0}}, row: {CW{1'b0}}, col: {CW{1'b0}}};
        end else if (clear_s) begin
            out_valid_r <= 1'b0;
        end else if (conv_en_s && issue_valid_s) begin
            out_valid_r <= 1'b1;
            out_tag_r   <= tag_s;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.filt_sel  = filt_r;
    assign bus.filt_load = filt_load_r;
    assign bus.rd_row    = row_r;
    assign bus.rd_col    = col_r;
    assign bus.conv_en   = conv_en_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_filt  = out_tag_r.filt;
    assign bus.out_row   = out_tag_r.row;
    assign bus.out_col   = out_tag_r.col;

endmodule

// File: tb/tb_conv554_ctrl.sv
// Bench for conv554_ctrl: directed timing steps plus a coordinate-order
// reference model of the full layer sweep under random backpressure.
module tb_conv554_ctrl;
    import lenet_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv554_ctrl_if #(.FW(FW), .CW(CW)) bus ();

    conv554_ctrl #(
        .IN_DIM(IN_DIM), .K(K), .NUM_FILT(NUM_FILT), .FW(FW), .CW(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int issue_q[$];
    int result_q[$];
    int n_res;
    int n_done;

    function automatic int coord(input int f, input int r, input int c);
        return f * 256 + r * 16 + c;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    // Expected issue order and result order of one whole layer pass.
    task automatic build_model();
        issue_q.delete();
        result_q.delete();
        n_res  = 0;
        n_done = 0;
        for (int f = 0; f < NUM_FILT; f++)
            for (int r = 0; r < OUT_DIM; r++)
                for (int c = 0; c < IN_DIM; c++) begin
                    issue_q.push_back(coord(f, r, c));
                    if (c >= K - 1) result_q.push_back(coord(f, r, c - (K - 1)));
                end
    endtask

    function automatic int cur_issue();
        return coord(int'(bus.filt_sel), int'(bus.rd_row), int'(bus.rd_col));
    endfunction

    function automatic int cur_tag();
        return coord(int'(bus.out_filt), int'(bus.out_row), int'(bus.out_col));
    endfunction

    task automatic observe();
        if (bus.conv_en === 1'b1) begin
            if (issue_q.size() == 0) chk("spurious_issue", 32'd1, 32'd0);
            else chk("issue_coord", 32'(cur_issue()), 32'(issue_q.pop_front()));
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_res++;
            if (result_q.size() == 0) chk("spurious_result", 32'd1, 32'd0);
            else chk("result_tag", 32'(cur_tag()), 32'(result_q.pop_front()));
        end
        if (bus.done === 1'b1) n_done++;
    endtask

    task automatic tick(input logic rdy, input logic st);
        @(posedge clk);
        #1;
        bus.start     = st;
        bus.out_ready = rdy;
        #1;
        observe();
    endtask

    task automatic check_idle(input string name);
        chk({name, "_busy"},      32'(bus.busy),      32'd0);
        chk({name, "_done"},      32'(bus.done),      32'd0);
        chk({name, "_filt_sel"},  32'(bus.filt_sel),  32'd0);
        chk({name, "_filt_load"}, 32'(bus.filt_load), 32'd0);
        chk({name, "_rd_row"},    32'(bus.rd_row),    32'd0);
        chk({name, "_rd_col"},    32'(bus.rd_col),    32'd0);
        chk({name, "_conv_en"},   32'(bus.conv_en),   32'd0);
        chk({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({name, "_out_tag"},   32'(cur_tag()),     32'd0);
    endtask

    task automatic run_until_issue(input int f, input int r, input int c);
        bit hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            tick(1'b1, 1'b0);
            if (bus.conv_en === 1'b1 && cur_issue() == coord(f, r, c)) hit = 1'b1;
        end
        chk("reach_issue", 32'(hit), 32'd1);
    endtask

    task automatic run_until_done(input bit rnd, input bit poke, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick(rnd ? logic'($urandom_range(0, 3) != 0) : 1'b1,
                 poke ? logic'($urandom_range(0, 63) == 0) : 1'b0);
            if (bus.done === 1'b1) begin
                hit = 1'b1;
                chk("done_with_busy", 32'(bus.busy), 32'd1);
            end
        end
        chk("done_seen", 32'(hit), 32'd1);
    endtask

    task automatic check_pass(input string name);
        chk({name, "_results"},   32'(n_res),            32'd1600);
        chk({name, "_issue_left"}, 32'(issue_q.size()),  32'd0);
        chk({name, "_res_left"},  32'(result_q.size()),  32'd0);
        tick(1'b1, 1'b0);
        chk({name, "_busy_after"}, 32'(bus.busy),        32'd0);
        repeat (5) tick(1'b1, 1'b0);
        chk({name, "_done_once"}, 32'(n_done),           32'd1);
    endtask

    initial begin
        bit hit;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("in_reset");
        rst = 1'b1;
        tick(1'b1, 1'b0);
        check_idle("post_reset");

        // Pass 1: directed timing with one 10-cycle stall.
        build_model();
        tick(1'b1, 1'b1);                       // cycle 0: start
        tick(1'b1, 1'b0);                       // cycle 1: LOAD
        chk("c1_filt_load", 32'(bus.filt_load), 32'd1);
        chk("c1_busy",      32'(bus.busy),      32'd1);
        chk("c1_conv_en",   32'(bus.conv_en),   32'd0);
        chk("c1_filt_sel",  32'(bus.filt_sel),  32'd0);
        tick(1'b1, 1'b0);                       // cycle 2: first issue
        chk("c2_conv_en",   32'(bus.conv_en),   32'd1);
        chk("c2_rd_col",    32'(bus.rd_col),    32'd0);
        chk("c2_rd_row",    32'(bus.rd_row),    32'd0);
        repeat (4) tick(1'b1, 1'b0);            // cycle 6
        chk("c6_out_valid", 32'(bus.out_valid), 32'd0);
        tick(1'b1, 1'b0);                       // cycle 7
        chk("c7_out_valid", 32'(bus.out_valid), 32'd1);
        chk("c7_tag",       32'(cur_tag()),     32'(coord(0, 0, 0)));
        repeat (2) tick(1'b1, 1'b0);            // cycle 9
        for (int i = 0; i < 10; i++) begin      // cycles 10..19 refused
            tick(1'b0, 1'b0);
            chk("bp_conv_en",   32'(bus.conv_en),   32'd0);
            chk("bp_rd_col",    32'(bus.rd_col),    32'd8);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_tag",       32'(cur_tag()),     32'(coord(0, 0, 3)));
        end
        tick(1'b1, 1'b0);
        chk("bp_resume_en",  32'(bus.conv_en), 32'd1);
        tick(1'b1, 1'b0);
        chk("bp_resume_tag", 32'(cur_tag()),   32'(coord(0, 0, 4)));

        run_until_issue(0, 0, 13);
        tick(1'b1, 1'b0);
        chk("wrap_issue", 32'(cur_issue()), 32'(coord(0, 1, 0)));
        chk("wrap_en",    32'(bus.conv_en), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            chk("wrap_fill_gap", 32'(bus.out_valid), 32'd0);
        end
        tick(1'b1, 1'b0);
        chk("wrap_first_tag", 32'(cur_tag()), 32'(coord(0, 1, 0)));

        run_until_issue(0, 9, 13);
        tick(1'b1, 1'b0);
        chk("fb_filt_load", 32'(bus.filt_load), 32'd1);
        chk("fb_filt_sel",  32'(bus.filt_sel),  32'd1);
        chk("fb_conv_en",   32'(bus.conv_en),   32'd0);
        chk("fb_last_tag",  32'(cur_tag()),     32'(coord(0, 9, 9)));

        run_until_done(1'b0, 1'b1, 4000);
        check_pass("pass1");

        // Pass 2: abort mid-stream at filter 3 row 5.
        build_model();
        tick(1'b1, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            tick(logic'($urandom_range(0, 3) != 0), 1'b0);
            if (bus.filt_sel === FW'(3) && bus.rd_row === CW'(5) && bus.conv_en === 1'b1) hit = 1'b1;
        end
        chk("abort_reached", 32'(hit), 32'd1);
        rst = 1'b0;
        #1;
        check_idle("async_rst");
        @(posedge clk);
        #1;
        check_idle("rst_next_cycle");
        rst = 1'b1;

        // Pass 3: fresh full layer under random backpressure and stray starts.
        build_model();
        tick(1'b1, 1'b1);
        run_until_done(1'b1, 1'b1, 12000);
        check_pass("pass3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
